// File: rtl/xgxs_tx_pkg.sv
// Shared XGXS transmit definitions: XGMII characters, code-group bytes and
// the per-lane control-character legaliser used ahead of the 8b/10b encoders.
package xgxs_tx_pkg;

  localparam int NUM_LANES = 4;

  localparam logic [7:0] IDLE  = 8'h07;
  localparam logic [7:0] START = 8'hFB;
  localparam logic [7:0] TERM  = 8'hFD;
  localparam logic [7:0] ERR   = 8'hFE;
  localparam logic [7:0] SEQ   = 8'h9C;

  localparam logic [7:0] K28_0 = 8'h1C;
  localparam logic [7:0] K28_3 = 8'h7C;
  localparam logic [7:0] K28_5 = 8'hBC;

  typedef struct packed {
    logic [7:0] data;
    logic       k;
  } lane_cg_t;

  // Start and sequence ordered sets are only legal when aligned to lane 0.
  function automatic lane_cg_t map_lane(input logic [7:0] d, input logic c,
                                        input logic is_lane0);
    lane_cg_t r;
    r.data = d;
    r.k    = c;
    if (c) begin
      case (d)
        IDLE:       r.data = K28_5;
        TERM, ERR:  r.data = d;
        START, SEQ: r.data = is_lane0 ? d : ERR;
        default:    r.data = ERR;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/xgxs_tx_lfsr7.sv
// PRBS7 (x^7 + x^6 + 1) randomiser for idle K/R selection and A spacing.
module xgxs_tx_lfsr7 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [6:0] seed,
  output logic [6:0] state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  state <= seed;
    else if (en) state <= {state[5:0], state[6] ^ state[5]};
  end

endmodule

// File: rtl/xgxs_tx_idle_gen.sv
// XGXS TX column processor: XGMII column -> four code-group bytes + K flags,
// with idle columns replaced by the randomised ||A||/||K||/||R|| sequence.
module xgxs_tx_idle_gen
  import xgxs_tx_pkg::*;
#(
  parameter int         A_MIN     = 16,
  parameter logic [6:0] LFSR_SEED = 7'h7F
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   col_vld,
  input  logic [NUM_LANES*8-1:0] txd,
  input  logic [NUM_LANES-1:0]   txc,
  output logic [NUM_LANES*8-1:0] enc_data,
  output logic [NUM_LANES-1:0]   enc_k,
  output logic                   enc_vld
);

  logic [6:0]                  lfsr;
  logic [4:0]                  a_cnt, nxt_cnt, a_reload;
  logic                        col_idle;
  logic [NUM_LANES-1:0][7:0]   map_data, nxt_data;
  logic [NUM_LANES-1:0]        map_k, nxt_k;
  logic                        lfsr_unused;

  xgxs_tx_lfsr7 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (col_vld),
    .seed  (LFSR_SEED),
    .state (lfsr)
  );

  assign lfsr_unused = ^lfsr[6:4];
  assign a_reload    = 5'(A_MIN) + {1'b0, lfsr[3:0]};
  assign col_idle    = (txc == '1) && (txd == {NUM_LANES{IDLE}});

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_cg_t cg;
    assign cg          = map_lane(txd[8*i +: 8], txc[i], (i == 0));
    assign map_data[i] = cg.data;
    assign map_k[i]    = cg.k;
  end

  // Idle columns take the column-wide A/K/R choice; data columns keep the
  // per-lane mapping and only run the A-spacing counter down.
  always_comb begin
    nxt_data = map_data;
    nxt_k    = map_k;
    nxt_cnt  = (a_cnt == 5'd0) ? 5'd0 : a_cnt - 5'd1;
    if (col_idle) begin
      nxt_k = '1;
      if (a_cnt == 5'd0) begin
        nxt_data = {NUM_LANES{K28_3}};
        nxt_cnt  = a_reload;
      end else begin
        nxt_data = lfsr[0] ? {NUM_LANES{K28_0}} : {NUM_LANES{K28_5}};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_data <= {NUM_LANES{K28_5}};
      enc_k    <= '1;
      enc_vld  <= 1'b0;
      a_cnt    <= 5'd0;
    end else begin
      enc_vld <= col_vld;
      if (col_vld) begin
        enc_data <= nxt_data;
        enc_k    <= nxt_k;
        a_cnt    <= nxt_cnt;
      end
    end
  end

endmodule

// File: tb/tb_xgxs_tx_idle_gen.sv
// Directed bench for xgxs_tx_idle_gen with a reference model feeding a
// scoreboard queue of expected columns.
module tb_xgxs_tx_idle_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        col_vld = 1'b0;
  logic [31:0] txd = 32'h0;
  logic [3:0]  txc = 4'h0;
  logic [31:0] enc_data;
  logic [3:0]  enc_k;
  logic        enc_vld;

  xgxs_tx_idle_gen dut (
    .clk(clk), .rst_n(rst_n), .col_vld(col_vld), .txd(txd), .txc(txc),
    .enc_data(enc_data), .enc_k(enc_k), .enc_vld(enc_vld)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] d; logic [3:0] k; } exp_t;
  exp_t exp_q[$];

  int n_chk = 0, n_pass = 0, n_fail = 0;
  logic [6:0] m_lfsr = 7'h7F;
  int         m_cnt  = 0;
  logic [31:0] last_d;
  logic [3:0]  last_k;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [8:0] ref_lane(input logic [7:0] b, input logic c, input int ln);
    if (!c) return {1'b0, b};
    if (b == 8'h07) return {1'b1, 8'hBC};
    if (b == 8'hFD || b == 8'hFE) return {1'b1, b};
    if ((b == 8'hFB || b == 8'h9C) && ln == 0) return {1'b1, b};
    return {1'b1, 8'hFE};
  endfunction

  function automatic exp_t ref_col(input logic [31:0] d, input logic [3:0] c);
    exp_t e;
    logic [8:0] l;
    if (c == 4'hF && d == 32'h07070707) begin
      e.k = 4'hF;
      if (m_cnt == 0) begin
        e.d = 32'h7C7C7C7C;
        m_cnt = 16 + int'(m_lfsr[3:0]);
      end else begin
        e.d = m_lfsr[0] ? 32'h1C1C1C1C : 32'hBCBCBCBC;
        m_cnt = m_cnt - 1;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        l = ref_lane(d[8*i +: 8], c[i], i);
        e.d[8*i +: 8] = l[7:0];
        e.k[i] = l[8];
      end
      if (m_cnt > 0) m_cnt = m_cnt - 1;
    end
    m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
    return e;
  endfunction

  // One clock step: drive at negedge, check 1 ns after the next rising edge.
  task automatic step(input logic v, input logic [31:0] d, input logic [3:0] c, input string tag);
    exp_t e;
    @(negedge clk);
    col_vld = v; txd = d; txc = c;
    if (v) exp_q.push_back(ref_col(d, c));
    @(posedge clk);
    #1;
    chk({tag, "_vld"}, {31'b0, enc_vld}, {31'b0, v});
    if (v) begin
      if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk({tag, "_data"}, enc_data, e.d);
        chk({tag, "_k"}, {28'b0, enc_k}, {28'b0, e.k});
      end
    end else begin
      chk({tag, "_hold_data"}, enc_data, last_d);
      chk({tag, "_hold_k"}, {28'b0, enc_k}, {28'b0, last_k});
    end
    last_d = enc_data;
    last_k = enc_k;
  endtask

  task automatic idle(input string tag);
    step(1'b1, 32'h07070707, 4'hF, tag);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", enc_data, 32'hBCBCBCBC);
    chk("rst_k", {28'b0, enc_k}, 32'hF);
    chk("rst_vld", {31'b0, enc_vld}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    idle("first_a");
    chk("first_a_const", enc_data, 32'h7C7C7C7C);
    idle("k1");
    chk("k1_const", enc_data, 32'hBCBCBCBC);
    idle("k2");
    chk("k2_const", enc_data, 32'hBCBCBCBC);
    for (int i = 0; i < 29; i++) idle("idle_run");
    idle("second_a");
    chk("second_a_const", enc_data, 32'h7C7C7C7C);

    step(1'b1, 32'h0707FD44, 4'hE, "term");
    chk("term_const", enc_data, 32'hBCBCFD44);
    step(1'b1, 32'h000000FB, 4'h2, "bad_ctl_l1");
    chk("bad_ctl_l1_const", enc_data, 32'h0000FEFB);
    step(1'b1, 32'h00550000, 4'h4, "bad_ctl_l2");
    chk("bad_ctl_l2_const", enc_data, 32'h00FE0000);
    step(1'b1, 32'h9CFB9CFB, 4'hF, "seq_start_lanes");
    step(1'b1, 32'hFEFD07FB, 4'hF, "ctl_mix");
    step(1'b1, 32'h44332211, 4'h0, "plain_data");

    for (int i = 0; i < 6; i++) idle("pre_freeze");
    for (int i = 0; i < 5; i++) step(1'b0, 32'h12345678, 4'h3, "freeze");
    for (int i = 0; i < 6; i++) idle("post_freeze");

    // Long data burst drains the A counter to zero, so the next idle is ||A||.
    for (int i = 0; i < 40; i++) step(1'b1, $urandom, 4'h0, "long_data");
    idle("sat_a");
    chk("sat_a_const", enc_data, 32'h7C7C7C7C);
    for (int i = 0; i < 5; i++) idle("idle_mid");

    for (int i = 0; i < 4; i++) step(1'b1, $urandom, 4'h0, "burst");
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_data", enc_data, 32'hBCBCBCBC);
    chk("midrst_k", {28'b0, enc_k}, 32'hF);
    chk("midrst_vld", {31'b0, enc_vld}, 32'd0);
    m_lfsr = 7'h7F;
    m_cnt  = 0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idle("after_rst_a");
    chk("after_rst_a_const", enc_data, 32'h7C7C7C7C);
    idle("after_rst_k");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/xgxs_tx_idle_gen.md
# xgxs_tx_idle_gen

Transmit-side XGXS column processor that sits directly upstream of the four per-lane 8b/10b encoder instances. It converts each 32-bit XGMII column (txd/txc) into four 8-bit code-group values plus K flags, driving each encoder's `encode_data_in` and `konstant`. It replaces XGMII idle columns with the randomised ||A||/||K||/||R|| idle sequence and maps illegal control characters to /E/. It has one register stage, an A-spacing counter and a PRBS7 randomiser.

## Interface
- `A_MIN`, default 16: minimum spacing in columns between ||A|| columns; the reload value is `A_MIN + lfsr[3:0]`.
- `LFSR_SEED`, default 7'h7F: PRBS7 value loaded on reset.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `col_vld` in 1: input column valid. When low, the block holds all state and outputs.
- `txd` in 32: XGMII data. Lane n is bits [8n+7:8n].
- `txc` in 4: XGMII control, one bit per lane.
- `enc_data` out 32: code-group byte per lane, same lane order as `txd`.
- `enc_k` out 4: K flag per lane, driving encoder `konstant`.
- `enc_vld` out 1: `enc_data`/`enc_k` hold a new column.

## Operation
- Idle column: all four lanes have txc=1 and txd=8'h07.
  - If `a_cnt`==0: emit ||A|| (8'h7C in all lanes, enc_k=4'hF) and load `a_cnt` with `A_MIN + lfsr[3:0]`.
  - Otherwise: emit ||K|| (8'hBC ×4) if lfsr[0]==0, else ||R|| (8'h1C ×4). `a_cnt` decrements.
- Non-idle column: `a_cnt` decrements, saturating at 0. Lanes are mapped individually:
  - txc=0: byte passes through, k=0.
  - txc=1, 8'h07: 8'hBC, k=1. This covers idle lanes after /T/.
  - txc=1, 8'hFD (T) or 8'hFE (E): passes through, k=1.
  - txc=1, 8'hFB (S) or 8'h9C (Q), lane 0 only: passes through, k=1. In lanes 1–3 it becomes 8'hFE.
  - txc=1, any other byte: 8'hFE, k=1.
- If `a_cnt` reaches 0 during data, ||A|| goes out at the first following idle column. Two consecutive ||A|| columns are impossible because the reload value is at least 16.
- LFSR: x^7+x^6+1. Update is `lfsr <= {lfsr[5:0], lfsr[6]^lfsr[5]}`, applied on each `col_vld` cycle. Decisions in a cycle use the pre-update value.
- `a_cnt` is 5 bits wide. Its reset value is 0, so the first idle column after reset is always ||A||.

## Timing
- Latency is 1 clock: column presented with `col_vld`=1 at edge N appears on `enc_*` after edge N, with `enc_vld`=1.
- `col_vld`=0: `enc_data`/`enc_k` hold their value, `enc_vld`=0, and `lfsr`/`a_cnt` are frozen.
- Reset (async assert, sync-safe deassert):
  - `enc_data`=32'hBCBCBCBC, `enc_k`=4'hF, `enc_vld`=0.
  - `lfsr`=`LFSR_SEED`, `a_cnt`=0.
- Reset asserted mid-stream: outputs return to reset values immediately. The first column after release follows the reset rules (||A|| if idle).
- Registered outputs meet the encoder's requirement: `konstant`=1 only with 8'h1C/7C/BC in idle columns.

## Structure
- Shared package `xgxs_tx_pkg` holds:
  - XGMII char constants: IDLE 8'h07, START 8'hFB, TERM 8'hFD, ERR 8'hFE, SEQ 8'h9C.
  - Code-group constants: K28_0 8'h1C, K28_3 8'h7C, K28_5 8'hBC.
  - Lane count (4).
- Sub-module `xgxs_tx_lfsr7` contains the PRBS7 register, with ports clk, rst_n, en, seed, and state out.
- Lane mapping is a per-lane function in the package; column-level A/K/R selection lives in the top.

## Test plan
- Reset release, then idle column (txd=32'h07070707, txc=4'hF) -> next cycle `enc_data`=32'h7C7C7C7C, enc_k=4'hF, `a_cnt`=31.
- Two further idle columns -> ||K|| then ||K|| (lfsr 7'h7E, 7'h7C). After 31 idle columns from the ||A||, the next ||A|| appears.
- Terminate column txd=32'h0707FD44, txc=4'hE -> enc_data=32'hBCBCFD44, enc_k=4'hE.
- Illegal control: txd=32'h000000FB with txc=4'h2, then txd lane 2 byte 8'h55 with txc bit 2 set -> lane 1 byte 8'hFE; lane 2 byte 8'hFE with k=1.
- `col_vld` low for 5 cycles mid-idle -> outputs frozen, `enc_vld`=0, and the A/K/R sequence resumes unchanged afterwards.
- `rst_n` pulse during a data burst -> outputs immediately 32'hBCBCBCBC/4'hF, and the first idle column after release is ||A||.
